alu_seq: RTL
============

# alu_seq

Parametrised, sequential successor to the CPU's 8-bit accumulator ALU. It keeps the original eight-opcode behaviour and adds wider datapaths, SUB, OR and shift operations, carry and overflow flags, and an iterative multi-cycle multiply. A start/busy/done handshake lets the controller stall on long operations. It sits between the accumulator register and the data bus, in the same slot as the current ALU.

## Interface
- WIDTH, 8: datapath width in bits; legal values are 4 to 32.
- clk  in  1: rising-edge clock.
- rst  in  1: asynchronous, active-high reset.
- alu_ena  in  1: start request; sampled on a clk edge only when busy=0.
- opcode  in  4: operation select.
- accum  in  WIDTH: accumulator operand (A).
- data  in  WIDTH: memory/bus operand (D).
- alu_out  out  WIDTH: registered result.
- zero  out  1: combinational, 1 when accum == 0.
- carry  out  1: registered carry/borrow/shift-out flag.
- ovf  out  1: registered signed-overflow flag.
- busy  out  1: high while a multiply is in progress.
- done  out  1: one-cycle pulse when a result or flag update completes.
- illegal  out  1: registered; set when a reserved opcode is accepted.

## Operation
- Opcodes:
  - 0000 HLT, 0001 SKZ, 0110 STO, 0111 JMP: alu_out = A.
  - 0010 ADD: A+D.
  - 0011 AND: A&D.
  - 0100 XOR: A^D.
  - 0101 LDA: alu_out = D.
  - 1000 SUB: A−D.
  - 1001 OR: A|D.
  - 1010 SHL: A<<1.
  - 1011 SHR: A>>1, logical.
  - 1100 MUL: low WIDTH bits of A*D, unsigned.
  - 1101–1111: reserved.
- Flags update only when an operation completes; otherwise they hold.
  - carry for ADD: carry-out.
  - carry for SUB: borrow, i.e. 1 when A<D unsigned.
  - carry for SHL: A[WIDTH-1].
  - carry for SHR: A[0].
  - carry for MUL: 1 when any upper WIDTH bits of the full product are nonzero.
  - carry for all other ops: 0.
  - ovf: two's-complement overflow for ADD/SUB; 0 for all other ops.
  - illegal: 1 for a reserved opcode, else 0.
- Reserved opcode: alu_out, carry and ovf hold; illegal=1; done pulses.
- FSM has two states, IDLE and MUL_RUN.
  - IDLE with alu_ena=1 and a non-MUL opcode: compute and register the result, pulse done, stay in IDLE.
  - IDLE with alu_ena=1 and opcode MUL:
    - Latch A as multiplier and D as multiplicand.
    - Clear the 2·WIDTH product register.
    - Load the iteration counter with WIDTH; set busy=1.
    - Go to MUL_RUN.
  - MUL_RUN, each cycle:
    - If multiplier[0]=1, add the multiplicand (zero-extended to 2·WIDTH) to the product.
    - Shift the multiplier right 1 and the multiplicand left 1.
    - Decrement the counter.
  - MUL_RUN, on the cycle the counter reaches 0:
    - alu_out = product[WIDTH-1:0].
    - carry = |product[2W-1:W].
    - ovf=0, illegal=0.
    - done=1, busy=0, go to IDLE.
- alu_ena while busy=1 is ignored and not queued. Operands and opcode may change freely during MUL_RUN.
- alu_ena=0 in IDLE: every output holds and done=0.

## Timing
- Reset (async assert, sync release):
  - alu_out=0, carry=0, ovf=0, busy=0, done=0, illegal=0.
  - FSM returns to IDLE and the counter is cleared.
  - zero still follows accum.
- Single-cycle ops: accepted at edge N. alu_out, flags and done=1 are valid after edge N; done drops after edge N+1 unless a new op is accepted at N+1.
- Back-to-back single-cycle ops are accepted every cycle; done stays high continuously.
- MUL: accepted at edge N; busy=1 after N; result and done=1 after edge N+WIDTH; busy=0 in the same cycle as done. The earliest next accept is edge N+WIDTH+1.
- alu_out during MUL_RUN holds the previous result.
- Reset mid-multiply aborts it: no done pulse, and alu_out reads 0.
- Wrap-around: ADD/SUB/MUL results are truncated mod 2^WIDTH; the lost information is reported only through carry.

## Test plan
- WIDTH=8, ADD A=0xF0, D=0x20 -> alu_out=0x10, carry=1, ovf=0, done pulses exactly 1 cycle after the accept edge.
- SUB A=0x80, D=0x01 -> alu_out=0x7F, carry=0, ovf=1. SUB A=0x01, D=0x02 -> alu_out=0xFF, carry=1, ovf=0.
- MUL A=0x0D, D=0x0B -> alu_out=0x8F, carry=0, busy high for exactly 8 cycles. An ADD pulse on alu_ena mid-run is ignored. MUL 0x10*0x10 -> alu_out=0x00, carry=1.
- SHL A=0x81 -> alu_out=0x02, carry=1. SHR A=0x81 -> alu_out=0x40, carry=1. Opcode 1110 -> alu_out holds, illegal=1, done=1. A following LDA D=0x5A -> alu_out=0x5A, illegal=0.
- Assert rst 3 cycles into MUL 0xFF*0xFF -> all outputs 0, busy=0, no done pulse. After release, ADD 0x01+0x01 -> alu_out=0x02.
- WIDTH=16, MUL 0x0100*0x0100 -> alu_out=0x0000, carry=1, latency 16 cycles. Random single-cycle ops checked against a reference model, including accum=0 -> zero=1.

Source files
------------

// File: rtl/alu_seq.sv
// ============================================================================
//  Module   : alu_seq
//  Brief    : Sequential accumulator ALU with flags and an iterative
//             shift-and-add multiplier behind a start/busy/done handshake.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_ena,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] accum,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] c_OP_HLT = 4'b0000;
    localparam logic [3:0] c_OP_SKZ = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_AND = 4'b0011;
    localparam logic [3:0] c_OP_XOR = 4'b0100;
    localparam logic [3:0] c_OP_LDA = 4'b0101;
    localparam logic [3:0] c_OP_STO = 4'b0110;
    localparam logic [3:0] c_OP_JMP = 4'b0111;
    localparam logic [3:0] c_OP_SUB = 4'b1000;
    localparam logic [3:0] c_OP_OR  = 4'b1001;
    localparam logic [3:0] c_OP_SHL = 4'b1010;
    localparam logic [3:0] c_OP_SHR = 4'b1011;
    localparam logic [3:0] c_OP_MUL = 4'b1100;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_t;

    state_t                 r_state, w_state;
    logic [WIDTH-1:0]       r_out, w_out;
    logic                   r_carry, w_carry;
    logic                   r_ovf, w_ovf;
    logic                   r_illegal, w_illegal;
    logic                   r_done, w_done;
    logic [WIDTH-1:0]       r_mplier, w_mplier;
    logic [2*WIDTH-1:0]     r_mcand, w_mcand;
    logic [2*WIDTH-1:0]     r_prod, w_prod;
    logic [CW-1:0]          r_cnt, w_cnt;

    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_diff;
    logic [2*WIDTH-1:0]     w_prod_add;

    // The extra top bit of sum/diff is the carry-out / borrow respectively.
    assign w_sum      = {1'b0, accum} + {1'b0, data};
    assign w_diff     = {1'b0, accum} - {1'b0, data};
    assign w_prod_add = r_prod + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_out     <= '0;
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_illegal <= 1'b0;
            r_done    <= 1'b0;
            r_mplier  <= '0;
            r_mcand   <= '0;
            r_prod    <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state;
            r_out     <= w_out;
            r_carry   <= w_carry;
            r_ovf     <= w_ovf;
            r_illegal <= w_illegal;
            r_done    <= w_done;
            r_mplier  <= w_mplier;
            r_mcand   <= w_mcand;
            r_prod    <= w_prod;
            r_cnt     <= w_cnt;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_out     = r_out;
        w_carry   = r_carry;
        w_ovf     = r_ovf;
        w_illegal = r_illegal;
        w_done    = 1'b0;
        w_mplier  = r_mplier;
        w_mcand   = r_mcand;
        w_prod    = r_prod;
        w_cnt     = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (alu_ena) begin
                    w_done    = 1'b1;
                    w_carry   = 1'b0;
                    w_ovf     = 1'b0;
                    w_illegal = 1'b0;
                    case (opcode)
                        c_OP_HLT, c_OP_SKZ, c_OP_STO, c_OP_JMP: w_out = accum;
                        c_OP_ADD: begin
                            w_out   = w_sum[WIDTH-1:0];
                            w_carry = w_sum[WIDTH];
                            w_ovf   = (accum[WIDTH-1] == data[WIDTH-1]) &&
                                      (w_sum[WIDTH-1] != accum[WIDTH-1]);
                        end
                        c_OP_AND: w_out = accum & data;
                        c_OP_XOR: w_out = accum ^ data;
                        c_OP_LDA: w_out = data;
                        c_OP_SUB: begin
                            w_out   = w_diff[WIDTH-1:0];
                            w_carry = w_diff[WIDTH];
                            w_ovf   = (accum[WIDTH-1] != data[WIDTH-1]) &&
                                      (w_diff[WIDTH-1] != accum[WIDTH-1]);
                        end
                        c_OP_OR:  w_out = accum | data;
                        c_OP_SHL: begin
                            w_out   = {accum[WIDTH-2:0], 1'b0};
                            w_carry = accum[WIDTH-1];
                        end
                        c_OP_SHR: begin
                            w_out   = {1'b0, accum[WIDTH-1:1]};
                            w_carry = accum[0];
                        end
                        c_OP_MUL: begin
                            // Flags keep their old values until the product is ready.
                            w_done    = 1'b0;
                            w_carry   = r_carry;
                            w_ovf     = r_ovf;
                            w_illegal = r_illegal;
                            w_mplier  = accum;
                            w_mcand   = {{WIDTH{1'b0}}, data};
                            w_prod    = '0;
                            w_cnt     = CW'(WIDTH);
                            w_state   = ST_MUL_RUN;
                        end
                        default: begin
                            w_carry   = r_carry;
                            w_ovf     = r_ovf;
                            w_illegal = 1'b1;
                        end
                    endcase
                end
            end
            ST_MUL_RUN: begin
                w_prod   = w_prod_add;
                w_mplier = r_mplier >> 1;
                w_mcand  = r_mcand << 1;
                w_cnt    = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_out     = w_prod_add[WIDTH-1:0];
                    w_carry   = |w_prod_add[2*WIDTH-1:WIDTH];
                    w_ovf     = 1'b0;
                    w_illegal = 1'b0;
                    w_done    = 1'b1;
                    w_state   = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    assign alu_out = r_out;
    assign carry   = r_carry;
    assign ovf     = r_ovf;
    assign illegal = r_illegal;
    assign done    = r_done;
    assign busy    = (r_state == ST_MUL_RUN);
    assign zero    = (accum == '0);

endmodule

`default_nettype wire
